// File: rtl/alu_pkg.sv
// Shared ALU types for the shift/arbiter slice: operation encoding, flag and
// response structs. ALU_SHIFT_ARB_RR_EN (see alu_shift_arbiter) does not affect this package.
package alu_pkg;

    localparam int ALU_MAX_WIDTH = 64;
    localparam int ALU_MAX_N_REQ = 4;
    localparam int ALU_ID_W      = $clog2(ALU_MAX_N_REQ);

    // Encodings 6..15 are undefined and reported through invalid_op.
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_SLLW = 4'd3,
        ALU_SRLW = 4'd4,
        ALU_SRAW = 4'd5
    } alu_op_t;

    typedef struct packed {
        logic invalid_op;
        logic zero;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_MAX_WIDTH-1:0] result;
        logic [ALU_ID_W-1:0]      id;
        logic                     invalid;
    } alu_resp_t;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_t;

    function automatic logic [63:0] sext_word(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter: full-width and 32-bit word shifts (word results are
// sign-extended); undefined operations yield zero with invalid_op set.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  alu_op_t          alu_op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt_s;
    logic [4:0]     shamt_w_s;
    logic [31:0]    word_s;
    logic           unused_s;

    assign shamt_s   = op_b[SHW-1:0];
    assign shamt_w_s = op_b[4:0];
    assign unused_s  = ^op_b;

    // Operation decode and shift datapath.
    always_comb begin
        word_s           = 32'h0;
        result           = {WIDTH{1'b0}};
        flags.invalid_op = 1'b0;
        case (alu_op)
            ALU_SLL:  result = op_a << shamt_s;
            ALU_SRL:  result = op_a >> shamt_s;
            ALU_SRA:  result = WIDTH'($signed(op_a) >>> shamt_s);
            ALU_SLLW: begin
                word_s = op_a[31:0] << shamt_w_s;
                result = WIDTH'(sext_word(word_s));
            end
            ALU_SRLW: begin
                word_s = op_a[31:0] >> shamt_w_s;
                result = WIDTH'(sext_word(word_s));
            end
            ALU_SRAW: begin
                word_s = 32'($signed(op_a[31:0]) >>> shamt_w_s);
                result = WIDTH'(sext_word(word_s));
            end
            default:  flags.invalid_op = 1'b1;
        endcase
        flags.zero = (result == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/alu_shift_arbiter.sv
// N_REQ requesters share one shifter behind a single-entry response register.
// Define ALU_SHIFT_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module alu_shift_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N_REQ = 2,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_op_a,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_op_b,
    input  alu_op_t [N_REQ-1:0]         req_alu_op,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [WIDTH-1:0]            resp_result,
    output logic [ID_W-1:0]             resp_id,
    output logic                        resp_invalid
);

    resp_state_t      state_r;
    alu_resp_t        resp_r;
    logic [N_REQ-1:0] grant_s;
    logic [ID_W-1:0]  win_idx_s;
    logic [ID_W-1:0]  idx_s;
    logic             found_s;
    logic             can_accept_s;
    logic             handshake_s;
    logic [WIDTH-1:0] sh_result_s;
    alu_flags_t       sh_flags_s;
    logic             unused_s;

`ifdef ALU_SHIFT_ARB_RR_EN
    logic [ID_W-1:0]  ptr_r;

    // Round-robin: first valid requester at or after the pointer, wrapping upward.
    always_comb begin
        grant_s   = {N_REQ{1'b0}};
        win_idx_s = {ID_W{1'b0}};
        idx_s     = {ID_W{1'b0}};
        found_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = ID_W'((int'(ptr_r) + k) % N_REQ);
            if (!found_s && req_valid[idx_s]) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                win_idx_s      = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end
`else
    // Fixed priority: lowest asserted index wins.
    always_comb begin
        grant_s   = {N_REQ{1'b0}};
        win_idx_s = {ID_W{1'b0}};
        idx_s     = {ID_W{1'b0}};
        found_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = ID_W'(k);
            if (!found_s && req_valid[idx_s]) begin
                found_s        = 1'b1;
                grant_s[idx_s] = 1'b1;
                win_idx_s      = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end
`endif

    // Reset gating keeps every req_ready low while rst_n is asserted.
    assign can_accept_s = rst_n & ((state_r == RESP_EMPTY) | resp_ready);
    assign handshake_s  = (|grant_s) & can_accept_s;
    assign req_ready    = grant_s & {N_REQ{can_accept_s}};

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .op_a   (req_op_a[win_idx_s]),
        .op_b   (req_op_b[win_idx_s]),
        .alu_op (req_alu_op[win_idx_s]),
        .result (sh_result_s),
        .flags  (sh_flags_s)
    );

    // Response register state machine and priority pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= RESP_EMPTY;
            resp_r  <= '0;
`ifdef ALU_SHIFT_ARB_RR_EN
            ptr_r   <= {ID_W{1'b0}};
`endif
        end else begin
            case (state_r)
                RESP_EMPTY: begin
                    if (handshake_s) begin
                        state_r <= RESP_FULL;
                    end else begin
                        state_r <= RESP_EMPTY;
                    end
                end
                RESP_FULL: begin
                    if (resp_ready && !handshake_s) begin
                        state_r <= RESP_EMPTY;
                    end else begin
                        state_r <= RESP_FULL;
                    end
                end
                default: state_r <= RESP_EMPTY;
            endcase
            if (handshake_s) begin
                resp_r.result  <= ALU_MAX_WIDTH'(sh_result_s);
                resp_r.id      <= ALU_ID_W'(win_idx_s);
                resp_r.invalid <= sh_flags_s.invalid_op;
`ifdef ALU_SHIFT_ARB_RR_EN
                ptr_r <= (int'(win_idx_s) == N_REQ - 1) ? {ID_W{1'b0}} : win_idx_s + 1'b1;
`endif
            end else begin
                resp_r <= resp_r;
            end
        end
    end

    assign resp_valid   = (state_r == RESP_FULL);
    assign resp_result  = resp_r.result[WIDTH-1:0];
    assign resp_id      = resp_r.id[ID_W-1:0];
    assign resp_invalid = resp_r.invalid;
    assign unused_s     = ^{resp_r, sh_flags_s.zero};

endmodule

// File: tb/tb_alu_shift_arbiter.sv
// Directed and random checks of alu_shift_arbiter against a cycle-level reference model.
module tb_alu_shift_arbiter;
    import alu_pkg::*;

    localparam int N = 2;
    localparam int W = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][W-1:0] op_a;
    logic [N-1:0][W-1:0] op_b;
    alu_op_t [N-1:0]     op;
    logic                resp_valid;
    logic                resp_ready;
    logic [W-1:0]        resp_result;
    logic [0:0]          resp_id;
    logic                resp_invalid;

    int total = 0;
    int bad = 0;

    // model state
    logic        m_valid = 1'b0;
    logic [63:0] m_result = 64'h0;
    int          m_id = 0;
    logic        m_inv = 1'b0;
    int          m_ptr = 0;
    int          exp_seq[4];

    alu_shift_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op_a     (op_a),
        .req_op_b     (op_b),
        .req_alu_op   (op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_id      (resp_id),
        .resp_invalid (resp_invalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_shift(input alu_op_t o, input logic [63:0] a,
                                              input logic [63:0] b, output logic inv);
        logic signed [63:0] sa;
        logic signed [31:0] sw;
        logic [31:0]        w;
        logic [63:0]        r;
        inv = 1'b0;
        r   = 64'h0;
        sa  = a;
        sw  = a[31:0];
        w   = 32'h0;
        case (o)
            ALU_SLL:  r = a << b[5:0];
            ALU_SRL:  r = a >> b[5:0];
            ALU_SRA:  r = sa >>> b[5:0];
            ALU_SLLW: begin w = a[31:0] << b[4:0]; r = {{32{w[31]}}, w}; end
            ALU_SRLW: begin w = a[31:0] >> b[4:0]; r = {{32{w[31]}}, w}; end
            ALU_SRAW: begin sw = sw >>> b[4:0]; r = {{32{sw[31]}}, sw}; end
            default:  begin r = 64'h0; inv = 1'b1; end
        endcase
        return r;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef ALU_SHIFT_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    // One clock: check req_ready before the edge, advance the model, check the response after.
    task automatic cycle();
        int          g;
        logic        can;
        logic [N-1:0] exp_rdy;
        logic [63:0] r;
        logic        inv;
        #1;
        g       = pick(req_valid, m_ptr);
        can     = rst_n && (!m_valid || resp_ready);
        exp_rdy = (g >= 0 && can) ? (N'(1) << g) : {N{1'b0}};
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_result = 64'h0; m_id = 0; m_inv = 1'b0; m_ptr = 0;
        end else if (g >= 0 && can) begin
            r = ref_shift(op[g], op_a[g], op_b[g], inv);
            m_valid = 1'b1; m_result = r; m_id = g; m_inv = inv; m_ptr = (g + 1) % N;
        end else if (m_valid && resp_ready) begin
            m_valid = 1'b0;
        end else begin
            m_valid = m_valid;
        end
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(m_valid));
        if (m_valid || !rst_n) begin
            chk("resp_result", resp_result, m_result);
            chk("resp_id", 64'(resp_id), 64'(m_id));
            chk("resp_invalid", 64'(resp_invalid), 64'(m_inv));
        end
    endtask

    initial begin
        // reset with requests pending
        rst_n = 1'b0; resp_ready = 1'b1; req_valid = 2'b11;
        op_a[0] = 64'h5; op_b[0] = 64'h1; op[0] = ALU_SLL;
        op_a[1] = 64'h9; op_b[1] = 64'h2; op[1] = ALU_SRL;
        cycle();
        cycle();
        chk("reset_valid", 64'(resp_valid), 64'h0);
        rst_n = 1'b1; req_valid = 2'b00;
        cycle();

        // single SLL, one-cycle latency, then drain
        op_a[0] = 64'h1; op_b[0] = 64'd4; op[0] = ALU_SLL; req_valid = 2'b01;
        cycle();
        chk("sll_result", resp_result, 64'h10);
        chk("sll_id", 64'(resp_id), 64'h0);
        req_valid = 2'b00;
        cycle();
        chk("sll_drain", 64'(resp_valid), 64'h0);

        // lone req1 grant (pointer wraps to 0 under round-robin)
        op_a[1] = 64'hF000; op_b[1] = 64'd8; op[1] = ALU_SRL; req_valid = 2'b10;
        cycle();
        chk("req1_result", resp_result, 64'hF0);

        // both requesting for four cycles
`ifdef ALU_SHIFT_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        op_a[0] = 64'h3; op_b[0] = 64'd2; op[0] = ALU_SLL;
        op_a[1] = 64'h8000_0000_0000_0000; op_b[1] = 64'd4; op[1] = ALU_SRA;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("arb_seq", 64'(resp_id), 64'(exp_seq[i]));
        end

        // backpressure for three cycles, then same-cycle grant on release
        req_valid = 2'b01; op_a[0] = 64'hF0; op_b[0] = 64'd4; op[0] = ALU_SRL;
        cycle();
        op_a[0] = 64'h1; op_b[0] = 64'd1; op[0] = ALU_SLL;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ready", 64'(req_ready), 64'h0);
            chk("stall_result", resp_result, 64'hF);
            chk("stall_id", 64'(resp_id), 64'h0);
        end
        resp_ready = 1'b1;
        #1;
        chk("release_ready", 64'(req_ready), 64'h1);
        cycle();
        chk("release_result", resp_result, 64'h2);

        // SRAW sign extension at 64 bits
        op_a[0] = 64'h8000_0000; op_b[0] = 64'd4; op[0] = ALU_SRAW;
        cycle();
        chk("sraw_result", resp_result, 64'hFFFF_FFFF_F800_0000);

        // reset while FULL (pointer at 1 under round-robin)
        rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b0;
        cycle();
        chk("rst_full_valid", 64'(resp_valid), 64'h0);
        rst_n = 1'b1; resp_ready = 1'b1; req_valid = 2'b11;
        cycle();
        chk("post_rst_id", 64'(resp_id), 64'h0);

        // undefined operation
        req_valid = 2'b01; op[0] = alu_op_t'(4'hF); op_a[0] = 64'hDEAD; op_b[0] = 64'd3;
        cycle();
        chk("inv_flag", 64'(resp_invalid), 64'h1);
        chk("inv_result", resp_result, 64'h0);
        req_valid = 2'b00;
        cycle();
        chk("inv_drain", 64'(resp_valid), 64'h0);

        // random traffic, backpressure, withdrawals and occasional reset
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            req_valid  = N'($urandom_range(0, 3));
            for (int j = 0; j < N; j++) begin
                op_a[j] = {$urandom, $urandom};
                op_b[j] = 64'($urandom_range(0, 63));
                op[j]   = alu_op_t'(4'($urandom_range(0, 7)));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_shift_arbiter.md
ALU_SHIFT_ARBITER -- requirements
Module: alu_shift_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning datapath width (32 or 64).
REQ-002 The block SHALL have parameter N_REQ, default 2, meaning number of requesters (2..4).
REQ-003 The block SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-006 The block SHALL have port req_ready  output  N_REQ  per-requester accept.
REQ-007 The block SHALL have port req_op_a  input  N_REQ x WIDTH  per-requester operand A.
REQ-008 The block SHALL have port req_op_b  input  N_REQ x WIDTH  per-requester operand B (shift amount in low bits).
REQ-009 The block SHALL have port req_alu_op  input  N_REQ x alu_op_t  per-requester operation.
REQ-010 The block SHALL have port resp_valid  output  1  response register holds a result.
REQ-011 The block SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-012 The block SHALL have port resp_result  output  WIDTH  shifter result.
REQ-013 The block SHALL have port resp_id  output  clog2(N_REQ)  index of the originating requester.
REQ-014 The block SHALL have port resp_invalid  output  1  shifter flagged invalid_op for this result.

Function
REQ-015 The block SHALL share one combinational shifter among all requesters; the arbitration winner's operands and op SHALL drive that shifter.
REQ-016 The response register SHALL be a two-state machine: EMPTY (resp_valid=0) or FULL (resp_valid=1).
REQ-017 The block SHALL define can_accept as EMPTY, or FULL with resp_ready=1 in the same cycle.
REQ-018 Grant SHALL be one-hot over the asserted req_valid bits; when no req_valid bit is asserted, grant SHALL be zero.
REQ-019 req_ready[i] SHALL equal grant[i] AND can_accept; it SHALL be combinational and SHALL NOT depend on req_valid[i] of other requesters beyond arbitration.
REQ-020 On a handshake with requester i, the next cycle SHALL have resp_valid=1, resp_result and resp_invalid taken from the shifter, and resp_id=i (latency exactly 1 cycle).
REQ-021 In FULL with resp_ready=1 and a new handshake in the same cycle, the register SHALL reload with the new result (back-to-back throughput of 1 per cycle).
REQ-022 In FULL with resp_ready=1 and no handshake, the state SHALL go to EMPTY.
REQ-023 In FULL with resp_ready=0, the state SHALL stay FULL, resp_* SHALL be held stable, and every req_ready bit SHALL be 0.
REQ-024 The priority pointer SHALL update only on a handshake; after a grant to requester i, it SHALL become (i+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-025 An invalid alu_op SHALL still be accepted and returned with resp_invalid=1 and resp_result=0.
REQ-026 For a request that is withdrawn before handshake, the block SHALL produce no response and SHALL leave the pointer unchanged.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set state EMPTY, resp_valid=0, resp_result=0, resp_id=0, resp_invalid=0, and pointer=0.
REQ-028 Reset SHALL discard a held response, and req_ready SHALL be 0 during reset cycles.

Configuration
REQ-029 With ALU_SHIFT_ARB_RR_EN defined, grant SHALL be round-robin: first asserted req_valid at or after the pointer, searching upward with wrap.
REQ-030 Without ALU_SHIFT_ARB_RR_EN, grant SHALL be fixed priority with the lowest asserted index winning, and the pointer register SHALL be omitted.

Structure
REQ-031 alu_op_t and alu_flags_t SHALL come from alu_pkg; a response struct type (result, id, invalid) and the N_REQ upper bound constant SHALL be added to alu_pkg.
REQ-032 The shared shifter SHALL be one instance of alu_shifter, and the block SHALL contain no other sub-module.

Verification
REQ-033 The bench SHALL drive req0 with op_a=0x1, op_b=4, ALU_SLL, and resp_ready=1 -> response next cycle with resp_result=0x10, resp_id=0, and resp_valid low after one cycle.
REQ-034 The bench SHALL hold req0 and req1 both valid for 4 cycles with RR enabled -> resp_id sequence 0,1,0,1; with RR disabled -> 0,0,0,0.
REQ-035 The bench SHALL hold resp_ready=0 for 3 cycles while FULL -> req_ready=0 on all requesters and resp_* stable, then on resp_ready=1 the pending request is granted in that same cycle.
REQ-036 The bench SHALL drive ALU_SRAW with op_a=0x80000000, op_b=4 at WIDTH=64 -> resp_result=0xFFFFFFFFF8000000.
REQ-037 The bench SHALL drive rst_n=0 for one cycle while FULL with pointer=1 -> resp_valid=0, and the next simultaneous req0/req1 request grants requester 0.
REQ-038 The bench SHALL send an undefined alu_op -> resp_invalid=1 and resp_result=0, with normal handshake completion.
